axi_read_slave_ctrl: RTL and testbench

- Parametrised AXI read slave endpoint.
- Accepts read addresses on the AR channel and forwards them to a simple in-order local read port.
- Buffers local responses in a response FIFO and returns them on the R channel.
- Supports up to OUTSTANDING transactions in flight, unlike the single-beat read channel bundle. Sits between the AXI interconnect and each peripheral or memory slave.

---
 rtl/axi_interface_pkg.sv | 14 +
 rtl/axi_read_slave_ctrl_pkg.sv | 20 ++
 rtl/axi_read_slave_ctrl_fifo.sv | 53 +++++
 rtl/axi_read_slave_ctrl.sv | 138 +++++++++++++
 tb/tb_axi_read_slave_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_interface_pkg.sv
// Shared AXI definitions: bus widths and the response code enumeration.
package axi_interface_pkg;

    localparam int unsigned AXI_ADDR_SIZE = 32;
    localparam int unsigned AXI_DATA_SIZE = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_response_t;

endpackage

// File: rtl/axi_read_slave_ctrl_pkg.sv
// Types for the AXI read slave: response FIFO entry and controller FSM states.
package axi_read_slave_ctrl_pkg;

    import axi_interface_pkg::*;

    localparam int unsigned RDATA_W = AXI_DATA_SIZE * 8;

    typedef struct packed {
        logic [RDATA_W-1:0] data;
        axi_response_t      resp;
    } axi_read_resp_t;

    localparam int unsigned RESP_W = $bits(axi_read_resp_t);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } axi_read_state_t;

endpackage

// File: rtl/axi_read_slave_ctrl_fifo.sv
// Synchronous response FIFO; head is presented combinationally and reads zero when empty.
module sync_fifo_resp #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/axi_read_slave_ctrl.sv
// AXI read slave endpoint with OUTSTANDING in-flight reads and an in-order response FIFO.
// Optional address decode with DECERR responses is enabled by AXI_READ_DECODE_EN.
module axi_read_slave_ctrl
    import axi_interface_pkg::*;
    import axi_read_slave_ctrl_pkg::*;
#(
    parameter int unsigned              OUTSTANDING = 4,
    parameter logic [AXI_ADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter logic [AXI_ADDR_SIZE-1:0] ADDR_RANGE  = AXI_ADDR_SIZE'('h1000)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [AXI_ADDR_SIZE-1:0]   ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [AXI_DATA_SIZE*8-1:0] RDATA,
    output axi_response_t              RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [AXI_ADDR_SIZE-1:0]   read_address_o,
    output logic                       read_request_o,
    input  logic [AXI_DATA_SIZE*8-1:0] read_data_i,
    input  logic                       read_error_i,
    input  logic                       read_done_i
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

`ifdef AXI_READ_DECODE_EN
    localparam bit DECODE_EN = 1'b1;
`else
    localparam bit DECODE_EN = 1'b0;
`endif

    axi_read_state_t          state_q, state_d;
    logic                     active_q;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         credit_c;
    logic [AXI_ADDR_SIZE-1:0] req_addr_q;
    logic                     req_q;
    logic                     addr_ok_c, credit_ok_c, done_ok_c;
    logic                     fwd_acc_c, dec_acc_c, ar_ready_c;
    logic                     push_c, pop_c, fifo_full, fifo_empty;
    axi_read_resp_t           push_entry_c, head;

    assign addr_ok_c   = !DECODE_EN ||
                         ((ARADDR >= BASE_ADDR) && ((ARADDR - BASE_ADDR) < ADDR_RANGE));
    assign credit_c    = CNT_W'(OUTSTANDING) - inflight_q - fifo_count;
    assign credit_ok_c = active_q && (credit_c != '0);
    assign done_ok_c   = read_done_i && (inflight_q != '0);

    // Accept control; an out-of-window address waits in DRAIN until older reads retire.
    always_comb begin
        state_d    = state_q;
        ar_ready_c = 1'b0;
        fwd_acc_c  = 1'b0;
        dec_acc_c  = 1'b0;
        inflight_d = inflight_q;
        unique case (state_q)
            IDLE: begin
                if (!addr_ok_c && (inflight_q != '0)) begin
                    if (ARVALID) state_d = DRAIN;
                end else begin
                    ar_ready_c = credit_ok_c;
                    fwd_acc_c  = ARVALID && credit_ok_c && addr_ok_c;
                    dec_acc_c  = ARVALID && credit_ok_c && !addr_ok_c;
                end
            end
            DRAIN: begin
                ar_ready_c = credit_ok_c && (inflight_q == '0);
                dec_acc_c  = ARVALID && ar_ready_c;
                if (dec_acc_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        inflight_d = inflight_q + CNT_W'(fwd_acc_c) - CNT_W'(done_ok_c);
    end

    always_comb begin
        push_entry_c = '0;
        push_c       = done_ok_c || dec_acc_c;
        if (dec_acc_c) begin
            push_entry_c.resp = DECERR;
        end else begin
            push_entry_c.data = read_data_i;
            push_entry_c.resp = read_error_i ? SLVERR : OKAY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            active_q   <= 1'b0;
            inflight_q <= '0;
            req_addr_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= 1'b1;
            inflight_q <= inflight_d;
            req_q      <= fwd_acc_c;
            if (fwd_acc_c) req_addr_q <= ARADDR;
        end
    end

    sync_fifo_resp #(
        .DEPTH (OUTSTANDING),
        .WIDTH (RESP_W)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_c),
        .data_i  (push_entry_c),
        .pop_i   (pop_c),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pop_c          = RVALID && RREADY;
    assign ARREADY        = ar_ready_c;
    assign RVALID         = !fifo_empty;
    assign RDATA          = head.data;
    assign RRESP          = head.resp;
    assign read_address_o = req_addr_q;
    assign read_request_o = req_q;

    a_done_with_inflight : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(read_done_i && (inflight_q == '0)))
        else $error("read_done_i asserted with no read in flight");

    a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_c && fifo_full))
        else $error("response FIFO push while full");

endmodule

// File: tb/tb_axi_read_slave_ctrl.sv
// Scoreboard bench for axi_read_slave_ctrl; decode scenario runs when AXI_READ_DECODE_EN is defined.
module tb_axi_read_slave_ctrl;

    import axi_interface_pkg::*;
    import axi_read_slave_ctrl_pkg::*;

    localparam int unsigned AW = AXI_ADDR_SIZE;
    localparam int unsigned DW = AXI_DATA_SIZE * 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [AW-1:0] ARADDR = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    axi_response_t RRESP;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [AW-1:0] read_address_o;
    logic          read_request_o;
    logic [DW-1:0] read_data_i = '0;
    logic          read_error_i = 1'b0;
    logic          read_done_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    axi_read_resp_t exp_q[$];
    logic [AW-1:0]  seen_addr[$];
    int unsigned    seen_cyc[$];

    axi_read_slave_ctrl dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .ARADDR         (ARADDR),
        .ARVALID        (ARVALID),
        .ARREADY        (ARREADY),
        .RDATA          (RDATA),
        .RRESP          (RRESP),
        .RVALID         (RVALID),
        .RREADY         (RREADY),
        .read_address_o (read_address_o),
        .read_request_o (read_request_o),
        .read_data_i    (read_data_i),
        .read_error_i   (read_error_i),
        .read_done_i    (read_done_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (read_request_o) begin
            seen_addr.push_back(read_address_o);
            seen_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ar_send(input logic [AW-1:0] a, output bit ok, output int unsigned acc);
        bit hs;
        ok = 1'b0;
        acc = 0;
        ARVALID = 1'b1;
        ARADDR = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            hs = ARREADY;
            step();
            if (hs) begin
                ok = 1'b1;
                acc = cyc;
                break;
            end
        end
    endtask

    task automatic local_done(input logic [DW-1:0] d, input bit err);
        axi_read_resp_t e;
        read_done_i = 1'b1;
        read_data_i = d;
        read_error_i = err;
        e.data = d;
        e.resp = err ? SLVERR : OKAY;
        exp_q.push_back(e);
        step();
        read_done_i = 1'b0;
        read_error_i = 1'b0;
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (RVALID) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp += 6;
        if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL reset_arready: got %b want 0", ARREADY); end
        if (RVALID !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", RVALID); end
        if (RDATA !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
        if (RRESP !== OKAY) begin n_bad++; $display("FAIL reset_rresp: got %0d want 0", RRESP); end
        if (read_request_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", read_request_o); end
        if (read_address_o !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", read_address_o); end
        rst_n_i = 1'b1;
        step();
        n_cmp++;
        if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL post_reset_arready: got %b want 1", ARREADY); end
    endtask

    task automatic test_single();
        bit ok;
        int unsigned acc;
        axi_read_resp_t e;
        RREADY = 1'b0;
        seen_addr.delete();
        seen_cyc.delete();
        ar_send(32'h10, ok, acc);
        ARVALID = 1'b0;
        step();
        step();
        n_cmp += 5;
        if (!ok) begin n_bad++; $display("FAIL single_accept: got no handshake want handshake"); end
        if (seen_addr.size() != 1) begin n_bad++; $display("FAIL single_req_count: got %0d want 1", seen_addr.size()); end
        else begin
            if (seen_addr[0] !== 32'h10) begin n_bad++; $display("FAIL single_req_addr: got %h want 10", seen_addr[0]); end
            if (seen_cyc[0] != acc) begin n_bad++; $display("FAIL single_req_cycle: got %0d want %0d", seen_cyc[0], acc); end
        end
        if (RVALID !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_early: got %b want 0", RVALID); end
        local_done(32'hDEADBEEF, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (RVALID !== 1'b1 || RDATA !== e.data || RRESP !== e.resp)
            begin n_bad++; $display("FAIL single_r: got v=%b d=%h r=%0d want v=1 d=%h r=%0d", RVALID, RDATA, RRESP, e.data, e.resp); end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        n_cmp++;
        if (RVALID !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_after_pop: got %b want 0", RVALID); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok;
        int unsigned acc[4];
        axi_read_resp_t e;
        RREADY = 1'b0;
        seen_addr.delete();
        seen_cyc.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ar_send(AW'(32'h100 + 4 * i), ok, acc[i]);
            if (!ok || acc[i] != acc[0] + i) all_ok = 1'b0;
        end
        n_cmp++;
        if (!all_ok) begin n_bad++; $display("FAIL b2b_accepts: got non-consecutive accepts want 4 consecutive"); end
        ARADDR = 32'h200;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL b2b_full_arready[%0d]: got %b want 0", i, ARREADY); end
            step();
        end
        ARVALID = 1'b0;
        n_cmp++;
        if (seen_addr.size() != 4) begin n_bad++; $display("FAIL b2b_req_count: got %0d want 4", seen_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seen_addr[i] !== AW'(32'h100 + 4 * i) || seen_cyc[i] != acc[i])
                    begin n_bad++; $display("FAIL b2b_req[%0d]: got a=%h c=%0d want a=%h c=%0d", i, seen_addr[i], seen_cyc[i], 32'h100 + 4 * i, acc[i]); end
            end
        end
        for (int i = 0; i < 4; i++) local_done($urandom, 1'b0);
        n_cmp++;
        if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL b2b_fifo_full_arready: got %b want 0", ARREADY); end
        RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rvalid(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || RDATA !== e.data || RRESP !== e.resp)
                begin n_bad++; $display("FAIL b2b_r[%0d]: got v=%b d=%h r=%0d want d=%h r=%0d", i, RVALID, RDATA, RRESP, e.data, e.resp); end
            step();
        end
        RREADY = 1'b0;
        n_cmp++;
        if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL b2b_arready_after: got %b want 1", ARREADY); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int unsigned acc;
        axi_read_resp_t e;
        RREADY = 1'b0;
        for (int i = 0; i < 4; i++) ar_send(AW'(32'h300 + 4 * i), ok, acc);
        ARVALID = 1'b0;
        step();
        for (int i = 0; i < 3; i++) local_done($urandom, 1'b0);
        n_cmp++;
        if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL bp_arready_full: got %b want 0", ARREADY); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q[0];
            for (int s = 0; s < 2; s++) begin
                n_cmp++;
                if (RVALID !== 1'b1 || RDATA !== e.data || RRESP !== e.resp)
                    begin n_bad++; $display("FAIL bp_stall[%0d.%0d]: got v=%b d=%h r=%0d want v=1 d=%h r=%0d", i, s, RVALID, RDATA, RRESP, e.data, e.resp); end
                step();
            end
            RREADY = 1'b1;
            step();
            RREADY = 1'b0;
            void'(exp_q.pop_front());
            if (i == 0) begin
                n_cmp++;
                if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL bp_arready_credit1: got %b want 1", ARREADY); end
            end
        end
        local_done($urandom, 1'b0);
        RREADY = 1'b1;
        wait_rvalid(ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || RDATA !== e.data || RRESP !== e.resp)
            begin n_bad++; $display("FAIL bp_last: got v=%b d=%h r=%0d want d=%h r=%0d", RVALID, RDATA, RRESP, e.data, e.resp); end
        step();
        RREADY = 1'b0;
    endtask

    task automatic test_error();
        bit ok;
        int unsigned acc;
        axi_read_resp_t e;
        axi_response_t want[3];
        want[0] = OKAY;
        want[1] = SLVERR;
        want[2] = OKAY;
        RREADY = 1'b0;
        for (int i = 0; i < 3; i++) ar_send(AW'(32'h400 + 4 * i), ok, acc);
        ARVALID = 1'b0;
        step();
        for (int i = 0; i < 3; i++) local_done($urandom, i == 1);
        RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_rvalid(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || RDATA !== e.data || RRESP !== want[i])
                begin n_bad++; $display("FAIL err_r[%0d]: got v=%b d=%h r=%0d want d=%h r=%0d", i, RVALID, RDATA, RRESP, e.data, want[i]); end
            step();
        end
        RREADY = 1'b0;
    endtask

`ifdef AXI_READ_DECODE_EN
    task automatic test_decode();
        bit ok;
        int unsigned acc;
        axi_read_resp_t e;
        RREADY = 1'b0;
        seen_addr.delete();
        seen_cyc.delete();
        ar_send(32'h20, ok, acc);
        ARADDR = 32'h2000;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL dec_hold[%0d]: got %b want 0", i, ARREADY); end
            step();
        end
        local_done($urandom, 1'b0);
        ar_send(32'h2000, ok, acc);
        ARVALID = 1'b0;
        e.data = '0;
        e.resp = DECERR;
        exp_q.push_back(e);
        step();
        step();
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL dec_accept: got no handshake want handshake"); end
        if (seen_addr.size() != 1) begin n_bad++; $display("FAIL dec_req_count: got %0d want 1", seen_addr.size()); end
        RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_rvalid(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || RDATA !== e.data || RRESP !== e.resp)
                begin n_bad++; $display("FAIL dec_r[%0d]: got v=%b d=%h r=%0d want d=%h r=%0d", i, RVALID, RDATA, RRESP, e.data, e.resp); end
            step();
        end
        RREADY = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        int unsigned acc;
        axi_read_resp_t e;
        RREADY = 1'b0;
        for (int i = 0; i < 3; i++) ar_send(AW'(32'h500 + 4 * i), ok, acc);
        ARVALID = 1'b0;
        step();
        local_done($urandom, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        n_cmp += 5;
        if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL mid_arready: got %b want 0", ARREADY); end
        if (RVALID !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid: got %b want 0", RVALID); end
        if (RDATA !== '0 || RRESP !== OKAY) begin n_bad++; $display("FAIL mid_r: got d=%h r=%0d want 0 0", RDATA, RRESP); end
        if (read_address_o !== '0) begin n_bad++; $display("FAIL mid_addr: got %h want 0", read_address_o); end
        if (read_request_o !== 1'b0) begin n_bad++; $display("FAIL mid_req: got %b want 0", read_request_o); end
        exp_q.delete();
        step();
        step();
        rst_n_i = 1'b1;
        step();
        seen_addr.delete();
        seen_cyc.delete();
        ar_send(32'h40, ok, acc);
        ARVALID = 1'b0;
        step();
        local_done(32'h0BADF00D, 1'b0);
        n_cmp += 2;
        if (seen_addr.size() != 1 || seen_addr[0] !== 32'h40)
            begin n_bad++; $display("FAIL mid_fresh_req: got n=%0d want 1 request to 40", seen_addr.size()); end
        e = exp_q.pop_front();
        if (RVALID !== 1'b1 || RDATA !== e.data || RRESP !== e.resp)
            begin n_bad++; $display("FAIL mid_fresh_r: got v=%b d=%h r=%0d want v=1 d=%h r=%0d", RVALID, RDATA, RRESP, e.data, e.resp); end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_error();
`ifdef AXI_READ_DECODE_EN
        test_decode();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
